// File: rtl/cpu_defs.sv
// Shared CPU-side definitions.
// Holds the default register-file geometry and the state encoding of the
// register readback scanner.
package cpu_defs;

  localparam int WORD_W     = 16;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    FINISH  = 2'd3
  } rb_state_e;

endpackage

// File: rtl/register_component.sv
// Single register with synchronous active-high reset and write enable.
// The register file is built from an array of these.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   we, d        : write enable and write data
//   q            : stored value
module register_component #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset)   q <= '0;
    else if (we) q <= d;
  end

endmodule

// File: rtl/reg_readback_unit.sv
// Register readback scanner.
// On start, walks first_idx..min(last_idx, NUM_REGS-1) through the register
// file's asynchronous read port and offers each word on a valid/ready stream.
// Ports:
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   start                : scan request, honoured only when idle
//   first_idx, last_idx  : inclusive scan range, captured with start
//   rf_addr, rf_data     : register file read address / combinational data
//   out_data, out_idx    : captured word and its index
//   out_valid, out_ready : output handshake
//   busy                 : scanner not idle
//   done                 : one-cycle pulse at scan completion
module reg_readback_unit
  import cpu_defs::*;
#(
  parameter int WIDTH    = WORD_W,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = REG_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [WIDTH-1:0]  rf_data,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(NUM_REGS - 1);

  rb_state_e         state, state_nx;
  logic [ADDR_W-1:0] idx, lim, lim_c;
  logic              empty_c, accept, last_word;

  // Clamp the upper bound to the file; any first index above the clamped
  // bound (including one past the end of the file) means nothing to send.
  assign lim_c     = (last_idx > MAX_IDX) ? MAX_IDX : last_idx;
  assign empty_c   = first_idx > lim_c;
  assign accept    = out_valid && out_ready;
  assign last_word = (idx == lim);

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = empty_c ? FINISH : FETCH;
      FETCH:   state_nx = PRESENT;
      PRESENT: if (accept) state_nx = last_word ? FINISH : FETCH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // rf_addr is loaded on the way into FETCH so it already equals idx during
  // the FETCH cycle, and otherwise keeps its last value.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx       <= '0;
      lim       <= '0;
      rf_addr   <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx <= first_idx;
            lim <= lim_c;
            if (!empty_c) rf_addr <= first_idx;
          end
        end
        FETCH: begin
          out_data  <= rf_data;
          out_idx   <= idx;
          out_valid <= 1'b1;
        end
        PRESENT: begin
          if (accept) begin
            out_valid <= 1'b0;
            // idx < lim here, so the increment cannot wrap.
            if (!last_word) begin
              idx     <= idx + ADDR_W'(1);
              rf_addr <= idx + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_readback_unit.sv
module tb_reg_readback_unit;

  localparam int W  = 16;
  localparam int NR = 16;
  localparam int AW = 5;

  typedef struct {
    logic [AW-1:0] idx;
    logic [W-1:0]  data;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] first_idx = '0, last_idx = '0;
  logic [AW-1:0] rf_addr;
  logic [W-1:0]  rf_data;
  logic [W-1:0]  out_data;
  logic [AW-1:0] out_idx;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy, done;

  logic          rf_rst = 1'b1;
  logic [NR-1:0] rf_we = '0;
  logic [W-1:0]  rf_wd = '0;
  logic [W-1:0]  rf_q [NR];

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  int   done_seen = 0;
  int   rdy_mode = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NR; g++) begin : g_rf
    register_component #(.WIDTH(W)) u_reg (
      .clock(clock), .reset(rf_rst), .we(rf_we[g]), .d(rf_wd), .q(rf_q[g])
    );
  end

  assign rf_data = (rf_addr < AW'(NR)) ? rf_q[rf_addr[3:0]] : '0;

  reg_readback_unit #(.WIDTH(W), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .first_idx(first_idx), .last_idx(last_idx),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .out_data(out_data), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // out_ready pattern: 0 = always high, 1 = toggles every 3 cycles, 2 = low.
  initial begin
    int rc = 0;
    forever begin
      @(posedge clock);
      #1;
      rc++;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((rc / 3) % 2) == 1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted word and checks that a
  // stalled word does not change.
  initial begin
    bit            held_v = 0;
    logic [W-1:0]  held_d;
    logic [AW-1:0] held_i;
    exp_t          e;
    forever begin
      @(negedge clock);
      if (done) done_seen++;
      if (out_valid) begin
        if (held_v) begin
          chk("stall_data_stable", int'(out_data), int'(held_d));
          chk("stall_idx_stable", int'(out_idx), int'(held_i));
        end
        if (out_ready) begin
          held_v = 0;
          if (q.size() == 0) begin
            chk("unexpected_word_idx", int'(out_idx), -1);
          end else begin
            e = q.pop_front();
            chk("word_idx", int'(out_idx), int'(e.idx));
            chk("word_data", int'(out_data), int'(e.data));
          end
        end else begin
          held_v = 1;
          held_d = out_data;
          held_i = out_idx;
        end
      end else begin
        held_v = 0;
      end
    end
  end

  task automatic push(input int i, input int d);
    exp_t e;
    e.idx  = AW'(i);
    e.data = W'(d);
    q.push_back(e);
  endtask

  // Runs one scan; exp_done < 0 means only "done must arrive".
  task automatic scan(input logic [AW-1:0] f, input logic [AW-1:0] l,
                      input int n_words, input int exp_done,
                      input int wr_at, input int xs_at);
    int cnt, got, fv, base;
    base = done_seen; fv = 0; got = 0; cnt = 1;
    first_idx = f; last_idx = l; start = 1'b1;
    tick;
    start = 1'b0;
    while (cnt <= 400) begin
      @(negedge clock);
      if (out_valid && fv == 0) fv = cnt;
      if (done) begin
        got = cnt;
        break;
      end
      start = (cnt == xs_at);
      if (cnt == xs_at) begin
        first_idx = '0;
        last_idx  = '0;
      end
      rf_wd = 16'hBEEF;
      rf_we = (cnt == wr_at) ? NR'(16'h0010) : '0;
      cnt++;
    end
    start = 1'b0;
    rf_we = '0;
    if (exp_done >= 0) chk("done_cycle", got, exp_done);
    else               chk("done_arrived", int'(got != 0), 1);
    chk("first_valid_cycle", fv, (n_words > 0) ? 2 : 0);
    @(negedge clock);
    chk("busy_after_done", int'(busy), 0);
    chk("done_pulse_count", done_seen - base, 1);
    chk("scoreboard_drained", q.size(), 0);
    tick;
  endtask

  initial begin
    int base;
    repeat (3) tick;
    @(negedge clock);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rf_addr", int'(rf_addr), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    tick;
    reset = 1'b0;
    rf_rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rf_we = '0;
      rf_we[i] = 1'b1;
      rf_wd = W'(16 * i);
      tick;
    end
    rf_we = '0;
    rdy_mode = 0;
    tick;

    // Full range, ready always high: word n accepted every 2 cycles.
    for (int i = 0; i < NR; i++) push(i, 16 * i);
    scan(5'd0, 5'd15, 16, 33, -1, -1);

    // Sub-range with a stalling consumer.
    rdy_mode = 1;
    push(3, 48); push(4, 64); push(5, 80);
    scan(5'd3, 5'd5, 3, -1, -1, -1);
    rdy_mode = 0;
    tick;

    // Empty ranges: inverted, and starting past the end of the file.
    scan(5'd7, 5'd2, 0, 1, -1, -1);
    scan(5'd18, 5'd20, 0, 1, -1, -1);

    // Upper bound clamped to the last register.
    push(14, 224); push(15, 240);
    scan(5'd14, 5'd20, 2, 5, -1, -1);

    // Second start while busy is ignored.
    push(8, 128); push(9, 144); push(10, 160);
    scan(5'd8, 5'd10, 3, 7, -1, 4);

    // Reset while a word is presented and stalled.
    rdy_mode = 2;
    tick;
    base = done_seen;
    first_idx = 5'd0; last_idx = 5'd15; start = 1'b1;
    tick;
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("pre_reset_valid", int'(out_valid), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_out_data", int'(out_data), 0);
    chk("abort_out_idx", int'(out_idx), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_rf_addr", int'(rf_addr), 0);
    reset = 1'b0;
    rdy_mode = 0;
    repeat (4) @(negedge clock);
    chk("abort_no_done", done_seen - base, 0);
    tick;

    // Register written during the scan, before its fetch.
    push(3, 48); push(4, 16'hBEEF); push(5, 80); push(6, 96);
    scan(5'd3, 5'd6, 4, 9, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
